// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared FIFO defaults and pointer wrap helper
package fifo_pkg;

  localparam int FIFO_DEPTH = 32;
  localparam int FIFO_WIDTH = 8;

  // Pointer increment that wraps at depth-1, so depth need not be a power of two.
  function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/bram.sv
// rtl/bram.sv - single-read/single-write block RAM, registered read, write-to-read bypass
module bram #(
  parameter int DEPTH      = 32,
  parameter int WIDTH      = 8,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clock,
  input  logic                  w_en,
  input  logic [ADDR_WIDTH-1:0] write_addr,
  input  logic [WIDTH-1:0]      write_data,
  input  logic                  r_en,
  input  logic [ADDR_WIDTH-1:0] read_addr,
  output logic [WIDTH-1:0]      read_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (w_en) mem[write_addr] <= write_data;
    // Same-address write and read return the new data, not the stale word.
    if (r_en) read_data <= (w_en && (write_addr == read_addr)) ? write_data : mem[read_addr];
  end

endmodule

// File: rtl/sync_fifo_ctrl.sv
// rtl/sync_fifo_ctrl.sv - first-word-fall-through FIFO controller around bram
// Optional almost_full/almost_empty decode under SYNC_FIFO_CTRL_ALMOST_FLAGS_EN.
module sync_fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int DEPTH      = FIFO_DEPTH,
  parameter int WIDTH      = FIFO_WIDTH,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int AF_THRESH  = DEPTH - 2,
  parameter int AE_THRESH  = 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  almost_full,
  output logic                  almost_empty
);

  localparam int CNT_W = ADDR_WIDTH + 1;

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [CNT_W-1:0]      mem_cnt;
  logic                  push;
  logic                  pop;
  logic                  fetch;

  assign in_ready = (count < CNT_W'(DEPTH));
  assign push     = in_valid & in_ready;
  assign pop      = out_valid & out_ready;
  // Refill the output stage whenever it is empty or being drained this cycle.
  assign fetch    = ((mem_cnt != '0) | push) & (~out_valid | out_ready);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      mem_cnt   <= '0;
      count     <= '0;
      out_valid <= 1'b0;
    end else begin
      if (push)  wr_ptr <= ADDR_WIDTH'(ptr_inc(32'(wr_ptr), DEPTH));
      if (fetch) rd_ptr <= ADDR_WIDTH'(ptr_inc(32'(rd_ptr), DEPTH));
      mem_cnt <= mem_cnt + CNT_W'(push) - CNT_W'(fetch);
      count   <= count + CNT_W'(push) - CNT_W'(pop);
      if (fetch)          out_valid <= 1'b1;
      else if (out_ready) out_valid <= 1'b0;
    end
  end

  // With the memory empty wr_ptr equals rd_ptr, so the bypass forwards in_data.
  bram #(
    .DEPTH      (DEPTH),
    .WIDTH      (WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_bram (
    .clock      (clock),
    .w_en       (push),
    .write_addr (wr_ptr),
    .write_data (in_data),
    .r_en       (fetch),
    .read_addr  (rd_ptr),
    .read_data  (out_data)
  );

`ifdef SYNC_FIFO_CTRL_ALMOST_FLAGS_EN
  assign almost_full  = (count >= CNT_W'(AF_THRESH));
  assign almost_empty = (count <= CNT_W'(AE_THRESH));
`else
  assign almost_full  = 1'b0;
  assign almost_empty = 1'b0;
`endif

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// tb/tb_sync_fifo_ctrl.sv - self-checking bench for sync_fifo_ctrl (DEPTH 32 and DEPTH 5)
module tb_sync_fifo_ctrl;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset_n;

  logic       a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_af, a_ae;
  logic [7:0] a_in_data, a_out_data;
  logic [5:0] a_count;

  logic       b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_af, b_ae;
  logic [7:0] b_in_data, b_out_data;
  logic [3:0] b_count;

  sync_fifo_ctrl #(.DEPTH(32), .WIDTH(8)) dut_a (
    .clock(clock), .reset_n(reset_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .count(a_count), .almost_full(a_af), .almost_empty(a_ae)
  );

  sync_fifo_ctrl #(.DEPTH(5), .WIDTH(8)) dut_b (
    .clock(clock), .reset_n(reset_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .count(b_count), .almost_full(b_af), .almost_empty(b_ae)
  );

  int checks = 0;
  int errors = 0;

  int         a_mcount = 0;
  logic [7:0] a_sb[$];
  int         a_npush = 0;
  int         a_npop = 0;

  typedef struct {
    logic       iv;
    logic [7:0] d;
    logic       ordy;
    int         exp_count;
    logic       exp_ov;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic exp_af(input int cnt, input int thresh);
`ifdef SYNC_FIFO_CTRL_ALMOST_FLAGS_EN
    return cnt >= thresh;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic exp_ae(input int cnt);
`ifdef SYNC_FIFO_CTRL_ALMOST_FLAGS_EN
    return cnt <= 1;
`else
    return 1'b0;
`endif
  endfunction

  // One cycle on the DEPTH=32 instance, checked against the occupancy model and scoreboard.
  task automatic step_a(input logic iv, input logic [7:0] d, input logic ordy);
    bit push, pop;
    @(negedge clock);
    a_in_valid  = iv;
    a_in_data   = d;
    a_out_ready = ordy;
    push = iv && (a_mcount < 32);
    pop  = ordy && (a_mcount > 0);
    check("a_count", a_count, a_mcount);
    check("a_out_valid", a_out_valid, a_mcount > 0);
    check("a_in_ready", a_in_ready, a_mcount < 32);
    check("a_almost_full", a_af, exp_af(a_mcount, 30));
    check("a_almost_empty", a_ae, exp_ae(a_mcount));
    if (pop) check("a_data", a_out_data, a_sb.pop_front());
    if (push) a_sb.push_back(d);
    a_npush += int'(push);
    a_npop  += int'(pop);
    @(posedge clock);
    a_mcount += int'(push) - int'(pop);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] held;
    int         b_mcount;
    logic [7:0] b_sb[$];
    bit         bp, bq;

    vecs[0] = '{1'b1, 8'h11, 1'b0, 1, 1'b1, 8'h11};
    vecs[1] = '{1'b0, 8'h00, 1'b0, 1, 1'b1, 8'h11};
    vecs[2] = '{1'b1, 8'h22, 1'b1, 1, 1'b1, 8'h22};
    vecs[3] = '{1'b0, 8'h00, 1'b1, 0, 1'b0, 8'h00};
    vecs[4] = '{1'b1, 8'h33, 1'b1, 1, 1'b1, 8'h33};
    vecs[5] = '{1'b1, 8'h44, 1'b1, 1, 1'b1, 8'h44};
    vecs[6] = '{1'b0, 8'h00, 1'b1, 0, 1'b0, 8'h00};

    reset_n = 1'b0;
    a_in_valid = 0; a_in_data = 0; a_out_ready = 0;
    b_in_valid = 0; b_in_data = 0; b_out_ready = 0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_count", a_count, 0);
    check("rst_out_valid", a_out_valid, 0);
    check("rst_in_ready", a_in_ready, 1);
    check("rst_almost_full", a_af, 0);
`ifdef SYNC_FIFO_CTRL_ALMOST_FLAGS_EN
    check("rst_almost_empty", a_ae, 1);
`else
    check("rst_almost_empty", a_ae, 0);
`endif
    check("rst_b_count", b_count, 0);
    @(negedge clock);
    reset_n = 1'b1;

    // Table vectors: first-word latency, simultaneous push/pop, empty boundaries.
    for (int i = 0; i < 7; i++) begin
      step_a(vecs[i].iv, vecs[i].d, vecs[i].ordy);
      check($sformatf("vec%0d_count", i), a_count, vecs[i].exp_count);
      check($sformatf("vec%0d_out_valid", i), a_out_valid, vecs[i].exp_ov);
      if (vecs[i].exp_ov) check($sformatf("vec%0d_data", i), a_out_data, vecs[i].exp_data);
    end

    // Fill to full; the 33rd offer is ignored.
    for (int i = 0; i < 33; i++) step_a(1'b1, 8'(i), 1'b0);
    check("full_count", a_count, 32);
    check("full_in_ready", a_in_ready, 0);
    check("full_sb_size", a_sb.size(), 32);

    // Sustained streaming from full: in_ready returns one cycle after the first pop.
    a_npush = 0; a_npop = 0;
    for (int i = 0; i < 100; i++) step_a(1'b1, 8'(8'h40 + i), 1'b1);
    check("stream_pops", a_npop, 100);
    check("stream_pushes", a_npush, 99);
    check("stream_count", a_count, 31);

    // Consumer stall with the producer still offering: head must not move.
    held = a_out_data;
    for (int i = 0; i < 5; i++) begin
      step_a(1'b1, 8'(8'hC0 + i), 1'b0);
      check("stall_data_stable", a_out_data, held);
    end
    check("stall_count", a_count, 32);

    for (int i = 0; i < 40 && a_mcount > 0; i++) step_a(1'b0, 8'h00, 1'b1);
    check("drain_count", a_count, 0);
    check("drain_sb_empty", a_sb.size(), 0);

    // Asynchronous reset with 7 entries stored.
    for (int i = 0; i < 7; i++) step_a(1'b1, 8'(8'h60 + i), 1'b0);
    check("pre_reset_count", a_count, 7);
    @(negedge clock);
    a_in_valid = 1'b1; a_out_ready = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_out_valid", a_out_valid, 0);
    check("async_rst_count", a_count, 0);
    check("async_rst_in_ready", a_in_ready, 1);
    a_in_valid = 1'b0; a_out_ready = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    a_mcount = 0;
    a_sb.delete();
    step_a(1'b1, 8'hA5, 1'b0);
    check("post_rst_out_valid", a_out_valid, 1);
    check("post_rst_data", a_out_data, 8'hA5);
    check("post_rst_count", a_count, 1);

    // Randomized handshakes on the DEPTH=5 instance.
    b_mcount = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clock);
      b_in_valid  = ($urandom_range(0, 3) != 0);
      b_in_data   = 8'($urandom);
      b_out_ready = (i < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      bp = b_in_valid && (b_mcount < 5);
      bq = b_out_ready && (b_mcount > 0);
      check("b_count", b_count, b_mcount);
      check("b_out_valid", b_out_valid, b_mcount > 0);
      check("b_in_ready", b_in_ready, b_mcount < 5);
      check("b_almost_full", b_af, exp_af(b_mcount, 3));
      check("b_almost_empty", b_ae, exp_ae(b_mcount));
      if (bq) check("b_data", b_out_data, b_sb.pop_front());
      if (bp) b_sb.push_back(b_in_data);
      @(posedge clock);
      b_mcount += int'(bp) - int'(bq);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
